// File: rtl/controlador_entrada.sv
// Purpose : switch input sequencer; waits for an operator enter press, captures and
//           sign-extends the switches, writes them to the register bank, pulses completion.
// Latency : request->aguardando 1 cycle; enter rise->capture 2-3 edges; ack->pronto 1 cycle.
// Backpressure: escrita_banco holds with dado stable until ack_banco is sampled high
//           (or, with ENTRADA_TIMEOUT_EN defined, until TIMEOUT_CYCLES cycles elapse).
//
// Ports:
//   clock, reset (async, active-low)
//   entradaSwitch[SW_W] raw two's-complement switches, enter (async button level)
//   req_entrada         control unit request level
//   ack_banco           register bank accepted the write
//   dado[DATA_W]        captured, sign-extended value (held until next capture)
//   escrita_banco       write valid to the register bank
//   pronto_entrada      one-cycle completion pulse
//   aguardando          waiting for enter (status LED)
//   erro_entrada        sticky ack-timeout flag (0 unless ENTRADA_TIMEOUT_EN)
// Optional feature macro: ENTRADA_TIMEOUT_EN
module controlador_entrada #(
    parameter int DATA_W         = 32,
    parameter int SW_W           = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SW_W-1:0]   entradaSwitch,
    input  logic              enter,
    input  logic              req_entrada,
    input  logic              ack_banco,
    output logic [DATA_W-1:0] dado,
    output logic              escrita_banco,
    output logic              pronto_entrada,
    output logic              aguardando,
    output logic              erro_entrada
);

    typedef enum logic [2:0] {
        OCIOSO,
        AGUARDA_ENTER,
        ESCREVE,
        CONCLUI,
        LIBERA
    } estado_t;

    estado_t           state_q, state_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              enter_s1_q, enter_s2_q, enter_prev_q;
    logic              enter_edge;
    logic              aguardando_q, escrita_q, pronto_q;

    // Synchronizer and edge-detect flops reset high: a button held through
    // reset looks "already pressed", so release produces no edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enter_s1_q   <= 1'b1;
            enter_s2_q   <= 1'b1;
            enter_prev_q <= 1'b1;
        end else begin
            enter_s1_q   <= enter;
            enter_s2_q   <= enter_s1_q;
            enter_prev_q <= enter_s2_q;
        end
    end

    assign enter_edge = enter_s2_q & ~enter_prev_q;

`ifdef ENTRADA_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             erro_q, erro_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            erro_q <= erro_d;
        end
    end

    assign erro_entrada = erro_q;
`else
    assign erro_entrada = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dado_d  = dado_q;
`ifdef ENTRADA_TIMEOUT_EN
        cnt_d   = cnt_q;
        erro_d  = erro_q;
`endif
        case (state_q)
            OCIOSO: begin
                if (req_entrada) state_d = AGUARDA_ENTER;
            end
            AGUARDA_ENTER: begin
                // Edge has priority over a request drop in the same cycle.
                if (enter_edge) begin
                    dado_d  = {{(DATA_W-SW_W){entradaSwitch[SW_W-1]}}, entradaSwitch};
                    state_d = ESCREVE;
`ifdef ENTRADA_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (!req_entrada) begin
                    state_d = OCIOSO;
                end
            end
            ESCREVE: begin
                // Request drop is ignored here: the write always completes.
                if (ack_banco) begin
                    state_d = CONCLUI;
                end
`ifdef ENTRADA_TIMEOUT_EN
                // cnt_q counts completed wait cycles; an ack in the last
                // allowed cycle still takes the success branch above.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = CONCLUI;
                    erro_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            CONCLUI: begin
                state_d = LIBERA;
            end
            LIBERA: begin
                // Holding off until the request drops keeps a level request
                // from re-triggering another input.
                if (!req_entrada) state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // Outputs are registered decodes of the next state, so they switch on
    // the same edge as the state and are glitch-free and mutually exclusive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= OCIOSO;
            dado_q       <= '0;
            aguardando_q <= 1'b0;
            escrita_q    <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dado_q       <= dado_d;
            aguardando_q <= (state_d == AGUARDA_ENTER);
            escrita_q    <= (state_d == ESCREVE);
            pronto_q     <= (state_d == CONCLUI);
        end
    end

    assign dado           = dado_q;
    assign aguardando     = aguardando_q;
    assign escrita_banco  = escrita_q;
    assign pronto_entrada = pronto_q;

endmodule

// File: doc/controlador_entrada.md
# controlador_entrada

Sequencer for the switch input path of the computer: when the control unit executes an input instruction it raises a request, and this block waits for the operator's `enter` press. It then captures and sign-extends the 9 switches and writes the result to the register bank with a valid/ack handshake. Finally it returns a one-cycle completion pulse to the control unit. It sits between the control unit, the switch/button pins and the register bank write port.

## Interface
- `DATA_W`, 32: width of `dado`; must be > `SW_W`.
- `SW_W`, 9: number of switches.
- `TIMEOUT_CYCLES`, 255: ack wait limit. Used only with the timeout macro.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `entradaSwitch` in `SW_W`: raw switch levels. Two's-complement; must be stable before `enter` is pressed.
- `enter` in 1: debounced button level, active-high, asynchronous to `clock`.
- `req_entrada` in 1: control unit input request (level).
- `ack_banco` in 1: register bank accepted the write, sampled on `clock`.
- `dado` out `DATA_W`: captured, sign-extended value.
- `escrita_banco` out 1: write valid to the register bank.
- `pronto_entrada` out 1: one-cycle completion pulse to the control unit.
- `aguardando` out 1: high while waiting for `enter`, for the status LED.
- `erro_entrada` out 1: sticky timeout flag.

## Operation
- **Enter synchronizer.** `enter` passes through 2 flops, then a previous-value flop.
  - Edge = sync2 & ~prev.
  - All three flops reset to 1, so a button held through reset never produces an edge.
- **States.** OCIOSO, AGUARDA_ENTER, ESCREVE, CONCLUI, LIBERA.
  - OCIOSO: `req_entrada`=1 -> AGUARDA_ENTER. Enter edges are ignored; there is no queuing.
  - AGUARDA_ENTER: `aguardando`=1.
    - Enter edge -> capture `dado` = {(`DATA_W`-`SW_W`) copies of `entradaSwitch[SW_W-1]`, `entradaSwitch`}, then go to ESCREVE.
    - `req_entrada`=0 with no edge -> OCIOSO (abort). `dado` is unchanged and there is no pulse.
    - Edge and request drop in the same cycle: the edge wins.
  - ESCREVE: `escrita_banco`=1 and `dado` is held stable.
    - `ack_banco`=1 -> CONCLUI.
    - `req_entrada` dropping here is ignored; the write always completes.
  - CONCLUI: `pronto_entrada`=1 for exactly this cycle -> LIBERA.
  - LIBERA: wait for `req_entrada`=0 -> OCIOSO. This prevents a held request from re-triggering.
- **Output persistence.** `dado` keeps its last captured value until the next capture.
- **Reset.** Reset at any time forces OCIOSO immediately.
  - `dado`=0, `escrita_banco`=0, `pronto_entrada`=0, `aguardando`=0, `erro_entrada`=0.
  - An in-flight write is dropped.

## Timing
- Request to `aguardando`: 1 cycle.
- `enter` rise to capture: 2–3 clock edges, depending on phase. ESCREVE is entered on the capture edge, so `escrita_banco` is high in the following cycle.
- Minimum `enter` high time: 2 clock periods.
- `ack_banco` high at edge N: `escrita_banco` low and `pronto_entrada` high after N. Zero-wait ack gives `escrita_banco` 1 cycle wide.
- Best case, request to `pronto_entrada`: 1 + sync + 2 cycles.
- `aguardando`, `escrita_banco` and `pronto_entrada` are registered state decodes, glitch-free and mutually exclusive.

## Configuration
- `ENTRADA_TIMEOUT_EN` defined:
  - A cycle counter runs in ESCREVE and clears on entry.
  - If `ack_banco` is not seen within `TIMEOUT_CYCLES` cycles: go to CONCLUI, set `erro_entrada`=1, and still pulse `pronto_entrada`.
  - `erro_entrada` clears only on reset.
  - Ack arriving in the final allowed cycle counts as success.
- Not defined:
  - ESCREVE waits for ack forever.
  - `erro_entrada` is tied to 0 and no counter is built.

## Test plan
- Switches 9'h0_7F, request high, enter pulse of 4 cycles, ack 1 cycle after `escrita_banco` -> `dado`=32'h0000007F, one `pronto_entrada` pulse, then LIBERA until the request drops.
- Switches 9'h1_80 (negative) -> `dado`=32'hFFFFFF80.
- Enter pressed in OCIOSO, then request raised -> no capture until a fresh press; `aguardando`=1 throughout.
- Request dropped in AGUARDA_ENTER -> OCIOSO, `dado` keeps its previous value, no `escrita_banco`, no pronto.
- Reset asserted mid-ESCREVE while `enter` is held through reset release -> all outputs 0 at once; no spurious capture after release.
- With `ENTRADA_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, ack never given -> CONCLUI after 4 cycles, `erro_entrada`=1, pronto pulsed once.
